// File: rtl/rgb_led_arbiter.sv
// Shares one RGB LED between N_REQ fixed-priority status requesters.
// A minimum-hold window prevents flicker, and a per-grant blink engine gates the colour.
module rgb_led_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MIN_HOLD   = 5,
  parameter int BLINK_HALF = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_100ms,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] color,
  input  logic [N_REQ-1:0]   blink,
  output logic [N_REQ-1:0]   gnt,
  output logic               r,
  output logic               g,
  output logic               b,
  output logic               busy
);

  localparam int         IDX_W      = $clog2(N_REQ);
  localparam logic [7:0] HOLD_LAST  = 8'(MIN_HOLD - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_HALF - 1);
  localparam bit         NO_HOLD    = (MIN_HOLD == 0);

  typedef enum logic [1:0] {IDLE, HOLD, OWN} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] winner;
  logic [7:0]       hold_cnt;
  logic [7:0]       blink_cnt;
  logic             phase;

  logic       any_req;
  logic       owner_req;
  logic       preempt;
  logic       take_grant;
  logic       release_idle;
  logic       blink_wrap;
  logic       phase_nxt;
  logic       own_blink;
  logic [2:0] own_color;
  logic [2:0] win_color;

  always_comb begin
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) winner = IDX_W'(i);
    end
    any_req      = |req;
    owner_req    = req[owner];
    preempt      = (state == OWN) && any_req && (winner < owner);
    // A released owner hands over straight to the next winner, so there is no gap cycle.
    take_grant   = ((state == IDLE) && any_req) ||
                   ((state != IDLE) && !owner_req && any_req) ||
                   preempt;
    release_idle = (state != IDLE) && !owner_req && !any_req;
    blink_wrap   = tick_100ms && (blink_cnt == BLINK_LAST);
    phase_nxt    = blink_wrap ? ~phase : phase;
    own_color    = color[3*owner +: 3];
    win_color    = color[3*winner +: 3];
    own_blink    = blink[owner];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      {r, g, b} <= 3'b000;
    end else if (take_grant) begin
      state     <= NO_HOLD ? OWN : HOLD;
      gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
      owner     <= winner;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      {r, g, b} <= win_color;
    end else if (release_idle) begin
      state     <= IDLE;
      gnt       <= '0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      {r, g, b} <= 3'b000;
    end else if (state != IDLE) begin
      if (tick_100ms) begin
        blink_cnt <= blink_wrap ? 8'd0 : blink_cnt + 8'd1;
        phase     <= phase_nxt;
        if (state == HOLD) begin
          hold_cnt <= hold_cnt + 8'd1;
          if (hold_cnt == HOLD_LAST) state <= OWN;
        end
      end
      // Colour is resampled every cycle so mid-grant changes show up without a restart.
      {r, g, b} <= own_color & {3{phase_nxt | ~own_blink}};
    end
  end

  assign busy = |gnt;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed testbench for rgb_led_arbiter: default build plus a MIN_HOLD=0 build.
module tb_rgb_led_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] color = '0;
  logic [3:0]  blink = '0;
  logic [3:0]  gnt;
  logic        r, g, b, busy;

  logic        z_tick = 1'b0;
  logic [3:0]  z_req = '0;
  logic [11:0] z_color = '0;
  logic [3:0]  z_blink = '0;
  logic [3:0]  z_gnt;
  logic        z_r, z_g, z_b, z_busy;

  int compared = 0;
  int mismatched = 0;

  rgb_led_arbiter #(.N_REQ(4), .MIN_HOLD(5), .BLINK_HALF(5)) dut (
    .clk(clk), .rst(rst), .tick_100ms(tick), .req(req), .color(color),
    .blink(blink), .gnt(gnt), .r(r), .g(g), .b(b), .busy(busy)
  );

  rgb_led_arbiter #(.N_REQ(4), .MIN_HOLD(0), .BLINK_HALF(5)) dut_z (
    .clk(clk), .rst(rst), .tick_100ms(z_tick), .req(z_req), .color(z_color),
    .blink(z_blink), .gnt(z_gnt), .r(z_r), .g(z_g), .b(z_b), .busy(z_busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    compared++;
    if (gnt !== 4'b0000) begin
      mismatched++; $display("[TB] FAIL reset_gnt got %b want 0000", gnt);
    end
    compared++;
    if ({r, g, b} !== 3'b000) begin
      mismatched++; $display("[TB] FAIL reset_rgb got %b want 000", {r, g, b});
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy);
    end
    compared++;
    if (z_gnt !== 4'b0000) begin
      mismatched++; $display("[TB] FAIL reset_z_gnt got %b want 0000", z_gnt);
    end
  endtask

  task automatic test_basic_grant();
    color = 12'b000_000_000_100;
    blink = 4'b0000;
    req   = 4'b0001;
    cyc();
    compared++;
    if (gnt !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL basic_gnt got %b want 0001", gnt);
    end
    compared++;
    if ({r, g, b} !== 3'b100) begin
      mismatched++; $display("[TB] FAIL basic_rgb got %b want 100", {r, g, b});
    end
    compared++;
    if (busy !== 1'b1) begin
      mismatched++; $display("[TB] FAIL basic_busy got %b want 1", busy);
    end
    req = 4'b0000;
    cyc();
    compared++;
    if (gnt !== 4'b0000 || {r, g, b} !== 3'b000 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_release got gnt=%b rgb=%b busy=%b want 0000/000/0", gnt, {r, g, b}, busy);
    end
  endtask

  task automatic test_hold_window();
    color = 12'b001_010_000_100;
    req   = 4'b0100;
    cyc();
    compared++;
    if (gnt !== 4'b0100 || {r, g, b} !== 3'b010) begin
      mismatched++; $display("[TB] FAIL hold_grant got gnt=%b rgb=%b want 0100/010", gnt, {r, g, b});
    end
    pulse_tick();
    pulse_tick();
    req = 4'b0101;
    cyc();
    compared++;
    if (gnt !== 4'b0100) begin
      mismatched++; $display("[TB] FAIL hold_ignore_early got %b want 0100", gnt);
    end
    pulse_tick();
    pulse_tick();
    compared++;
    if (gnt !== 4'b0100) begin
      mismatched++; $display("[TB] FAIL hold_after4 got %b want 0100", gnt);
    end
    pulse_tick();
    compared++;
    if (gnt !== 4'b0100) begin
      mismatched++; $display("[TB] FAIL hold_tick5 got %b want 0100", gnt);
    end
    cyc();
    compared++;
    if (gnt !== 4'b0001 || {r, g, b} !== 3'b100) begin
      mismatched++; $display("[TB] FAIL hold_preempt got gnt=%b rgb=%b want 0001/100", gnt, {r, g, b});
    end
  endtask

  task automatic test_low_priority_and_release();
    for (int i = 0; i < 5; i++) pulse_tick();
    req = 4'b1001;
    for (int i = 0; i < 10; i++) cyc();
    compared++;
    if (gnt !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL lowprio_no_preempt got %b want 0001", gnt);
    end
    req = 4'b1000;
    cyc();
    compared++;
    if (gnt !== 4'b1000 || busy !== 1'b1 || {r, g, b} !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL handover got gnt=%b busy=%b rgb=%b want 1000/1/001", gnt, busy, {r, g, b});
    end
    req = 4'b0000;
    cyc();
    compared++;
    if (gnt !== 4'b0000) begin
      mismatched++; $display("[TB] FAIL handover_idle got %b want 0000", gnt);
    end
  endtask

  task automatic test_blink();
    logic [2:0] exp;
    color = 12'b000_000_011_000;
    blink = 4'b0010;
    req   = 4'b0010;
    cyc();
    compared++;
    if ({r, g, b} !== 3'b011) begin
      mismatched++; $display("[TB] FAIL blink_start got %b want 011", {r, g, b});
    end
    for (int t = 1; t <= 20; t++) begin
      pulse_tick();
      cyc();
      exp = (((t / 5) % 2) == 0) ? 3'b011 : 3'b000;
      compared++;
      if ({r, g, b} !== exp) begin
        mismatched++; $display("[TB] FAIL blink_tick%0d got %b want %b", t, {r, g, b}, exp);
      end
    end
    pulse_tick();
    pulse_tick();
    color = 12'b000_000_110_000;
    cyc();
    compared++;
    if ({r, g, b} !== 3'b110) begin
      mismatched++; $display("[TB] FAIL blink_color_change got %b want 110", {r, g, b});
    end
    pulse_tick();
    pulse_tick();
    pulse_tick();
    compared++;
    if ({r, g, b} !== 3'b000) begin
      mismatched++; $display("[TB] FAIL blink_no_restart got %b want 000", {r, g, b});
    end
    req = 4'b0000;
    cyc();
  endtask

  task automatic test_reset_midgrant();
    color = 12'b000_000_011_100;
    blink = 4'b0010;
    req   = 4'b0010;
    cyc();
    pulse_tick();
    pulse_tick();
    pulse_tick();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    compared++;
    if (gnt !== 4'b0000 || {r, g, b} !== 3'b000 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midreset got gnt=%b rgb=%b busy=%b want 0000/000/0", gnt, {r, g, b}, busy);
    end
    cyc();
    compared++;
    if (gnt !== 4'b0010 || {r, g, b} !== 3'b011) begin
      mismatched++; $display("[TB] FAIL midreset_regrant got gnt=%b rgb=%b want 0010/011", gnt, {r, g, b});
    end
    for (int i = 0; i < 4; i++) pulse_tick();
    compared++;
    if ({r, g, b} !== 3'b011) begin
      mismatched++; $display("[TB] FAIL midreset_fresh_phase got %b want 011", {r, g, b});
    end
    req = 4'b0011;
    cyc();
    compared++;
    if (gnt !== 4'b0010) begin
      mismatched++; $display("[TB] FAIL midreset_fresh_hold got %b want 0010", gnt);
    end
    pulse_tick();
    compared++;
    if (gnt !== 4'b0010 || {r, g, b} !== 3'b000) begin
      mismatched++; $display("[TB] FAIL midreset_tick5 got gnt=%b rgb=%b want 0010/000", gnt, {r, g, b});
    end
    cyc();
    compared++;
    if (gnt !== 4'b0001 || {r, g, b} !== 3'b100) begin
      mismatched++; $display("[TB] FAIL midreset_preempt got gnt=%b rgb=%b want 0001/100", gnt, {r, g, b});
    end
    req = 4'b0000;
    cyc();
  endtask

  task automatic test_min_hold_zero();
    z_color = 12'b000_010_000_100;
    z_req   = 4'b0100;
    cyc();
    compared++;
    if (z_gnt !== 4'b0100 || {z_r, z_g, z_b} !== 3'b010) begin
      mismatched++; $display("[TB] FAIL zhold_grant got gnt=%b rgb=%b want 0100/010", z_gnt, {z_r, z_g, z_b});
    end
    z_req = 4'b0101;
    cyc();
    compared++;
    if (z_gnt !== 4'b0001 || {z_r, z_g, z_b} !== 3'b100 || z_busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL zhold_preempt got gnt=%b rgb=%b busy=%b want 0001/100/1", z_gnt, {z_r, z_g, z_b}, z_busy);
    end
    z_req = 4'b0000;
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_hold_window();
    test_low_priority_and_release();
    test_blink();
    test_reset_midgrant();
    test_min_hold_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
